inst_bus_if: RTL and testbench
==============================

Name: inst_bus_if

Overview:
- Instruction-side bus master directly downstream of the PC register.
- Consumes the fetch address and chip-enable, then runs a Wishbone-style classic read cycle to instruction memory.
- Returns the fetched word to the IF/ID pipeline register.
- Raises a stall request to the pipeline controller while a fetch is outstanding; also handles pipeline stall, flush and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without ack before the fetch aborts. Legal range 2..255; 8-bit counter.
- NOP_INST, 32'h00000000: word returned on abort, flush and idle.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  6  pipeline stall vector; nonzero means pipeline held
- flush  input  1  pipeline flush; discards any fetch in progress
- cpu_ce_i  input  1  fetch enable from PC register
- cpu_addr_i  input  32  fetch address (word aligned)
- cpu_data_o  output  32  instruction to IF/ID, combinational
- stallreq_o  output  1  fetch-pending stall request, combinational
- bus_err_o  output  1  one-cycle pulse on timeout abort, registered
- wb_adr_o  output  32  bus address, registered
- wb_dat_i  input  32  bus read data
- wb_ack_i  input  1  bus acknowledge
- wb_cyc_o  output  1  bus cycle, registered
- wb_stb_o  output  1  bus strobe, registered
- wb_we_o  output  1  constant 0
- wb_sel_o  output  4  constant 4'b1111

Behaviour:
Reset:
- State IDLE.
- wb_adr_o=0, wb_cyc_o=0, wb_stb_o=0, bus_err_o=0.
- rd_buf=0, timer=0.
- stallreq_o=0 and cpu_data_o=NOP_INST while rst=1.
- Reset mid-transaction: cyc/stb drop at that edge; no ack is honoured afterwards.

States IDLE, BUSY, WAIT_STALL; flush has priority over every other event.

IDLE:
- Request condition: cpu_ce_i=1 and flush=0.
  - Combinational: stallreq_o=1, cpu_data_o=NOP_INST.
  - Next edge: wb_adr_o<=cpu_addr_i, cyc/stb<=1, timer<=0, go BUSY.
- Otherwise: stallreq_o=0, cpu_data_o=NOP_INST, stay.

BUSY (cyc=stb=1):
- flush=1: cyc/stb<=0, wb_adr_o<=0, rd_buf<=0, go IDLE. stallreq_o=0 this cycle.
  - A simultaneous ack is discarded.
- Else wb_ack_i=1:
  - Combinational: cpu_data_o=wb_dat_i, stallreq_o=0.
  - Next edge: cyc/stb<=0, wb_adr_o<=0.
  - If stall!=0: rd_buf<=wb_dat_i, go WAIT_STALL; else go IDLE.
  - Ack latency from request edge to data delivery: minimum 1 cycle.
- Else timer==TIMEOUT_CYCLES-1:
  - Combinational: cpu_data_o=NOP_INST, stallreq_o=0.
  - Next edge: cyc/stb<=0, bus_err_o<=1 for one cycle, go IDLE.
- Else: stallreq_o=1, cpu_data_o=NOP_INST, timer<=timer+1.
  - Timer never wraps; abort fires at exactly TIMEOUT_CYCLES cycles in BUSY.

WAIT_STALL:
- Combinational: cpu_data_o=rd_buf, stallreq_o=0.
- flush=1: rd_buf<=0, go IDLE.
- Else stall==0: go IDLE. Next fetch request may start that same IDLE cycle.
- Else: hold.

General:
- bus_err_o is 0 in every cycle other than the pulse.
- wb_adr_o is stable for the whole BUSY interval.
- Address passes through unmodified; no alignment check.

Test Plan:
1. Ack delay 3: rst released, cpu_ce_i=1, cpu_addr_i=32'h00000004, memory acks 3 cycles after cyc rises with 32'h34011100.
   -> wb_adr_o=32'h4, cyc=stb=1 for 3 cycles, stallreq_o=1 through them.
   -> On ack cycle: cpu_data_o=32'h34011100, stallreq_o=0; cyc=0 next cycle.
2. Zero-wait ack: same-cycle ack every BUSY cycle.
   -> Alternating IDLE/BUSY, one instruction every 2 cycles, bus_err_o never 1.
3. Stall at ack: stall=6'b000011 asserted at ack with data 32'hDEADBEEF, held 4 cycles.
   -> State WAIT_STALL, cpu_data_o=32'hDEADBEEF, stallreq_o=0 for 4 cycles.
   -> Returns to IDLE when stall=0.
4. Flush during fetch: flush=1 in 2nd BUSY cycle, ack with 32'h12345678 that same cycle.
   -> Data discarded, cpu_data_o=0, cyc=0 next cycle, state IDLE.
5. Timeout: TIMEOUT_CYCLES=4, no ack.
   -> cyc high exactly 4 cycles, cpu_data_o=0 and stallreq_o=0 in 4th, bus_err_o=1 for one cycle after, cyc=0.
6. Reset mid-op: rst=1 in BUSY.
   -> Next edge: cyc=stb=0, wb_adr_o=0, stallreq_o=0 while rst=1; late ack ignored; state IDLE.

Source files
------------

// File: rtl/inst_bus_if.sv
// Instruction-side Wishbone classic read master between the PC register and IF/ID.
// Handles pipeline stall and flush, and aborts a fetch that is never acknowledged.
module inst_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StWaitStall} state_e;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [31:0] adr_q;
    logic [31:0] rd_buf_q;
    logic        cyc_q;
    logic        err_q;
    logic [7:0]  timer_q;

    logic        ack_take;
    logic        timeout;

    // Flush outranks ack, and ack outranks the timeout in the same cycle.
    assign ack_take = (state_q == StBusy) && !flush && wb_ack_i;
    assign timeout  = (state_q == StBusy) && !flush && !wb_ack_i && (timer_q == TimerLast);

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = NOP_INST;
        if (!rst) begin
            case (state_q)
                StIdle:      stallreq_o = cpu_ce_i && !flush;
                StBusy: begin
                    if (ack_take) begin
                        cpu_data_o = wb_dat_i;
                    end else if (!flush && !timeout) begin
                        stallreq_o = 1'b1;
                    end
                end
                StWaitStall: cpu_data_o = rd_buf_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            adr_q    <= 32'h0;
            rd_buf_q <= 32'h0;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= 8'h0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cpu_ce_i && !flush) begin
                        adr_q   <= cpu_addr_i;
                        cyc_q   <= 1'b1;
                        timer_q <= 8'h0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (flush) begin
                        cyc_q    <= 1'b0;
                        adr_q    <= 32'h0;
                        rd_buf_q <= 32'h0;
                        state_q  <= StIdle;
                    end else if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        adr_q <= 32'h0;
                        if (stall != 6'b0) begin
                            rd_buf_q <= wb_dat_i;
                            state_q  <= StWaitStall;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (timer_q == TimerLast) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StWaitStall: begin
                    if (flush) begin
                        rd_buf_q <= 32'h0;
                        state_q  <= StIdle;
                    end else if (stall == 6'b0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign bus_err_o = err_q;
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = 4'b1111;

endmodule

// File: tb/tb_inst_bus_if.sv
// Directed bench for inst_bus_if: stimulus pushes expected deliveries and bus errors into a
// scoreboard that a separate monitor drains; cycle-level checks are made inline.
module tb_inst_bus_if;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    inst_bus_if #(
        .TIMEOUT_CYCLES(4),
        .NOP_INST      (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o),
        .bus_err_o (bus_err_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [31:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    // Monitor: a delivery is an acked bus cycle not killed by flush or reset.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && wb_cyc_o && wb_ack_i && !flush) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_delivery", cpu_data_o, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_delivery_kind", {31'b0, e.is_err}, 32'd0);
                    chk("sb_delivery_data", cpu_data_o, e.data);
                    chk("sb_delivery_stallreq", {31'b0, stallreq_o}, 32'd0);
                end
            end
            if (bus_err_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_bus_err", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_bus_err_kind", {31'b0, e.is_err}, 32'd1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 6'b0; flush = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h40;
        wb_dat_i = 32'h0; wb_ack_i = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_stallreq", {31'b0, stallreq_o}, 32'd0);
        chk("rst_data", cpu_data_o, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
        chk("const_we", {31'b0, wb_we_o}, 32'd0);
        chk("const_sel", {28'b0, wb_sel_o}, 32'hf);

        // 1: ack on the 4th BUSY cycle, which also beats the timeout
        step();
        rst = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h4;
        @(negedge clk);
        chk("t1_idle_stallreq", {31'b0, stallreq_o}, 32'd1);
        chk("t1_idle_cyc", {31'b0, wb_cyc_o}, 32'd0);
        push_exp(1'b0, 32'h3401_1100);
        step();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_busy_cyc", {31'b0, wb_cyc_o}, 32'd1);
            chk("t1_busy_stb", {31'b0, wb_stb_o}, 32'd1);
            chk("t1_busy_adr", wb_adr_o, 32'h4);
            chk("t1_busy_stallreq", {31'b0, stallreq_o}, 32'd1);
            chk("t1_busy_data", cpu_data_o, 32'h0);
            step();
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h3401_1100;
        @(negedge clk);
        chk("t1_ack_data", cpu_data_o, 32'h3401_1100);
        chk("t1_ack_stallreq", {31'b0, stallreq_o}, 32'd0);
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        @(negedge clk);
        chk("t1_after_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("t1_after_adr", wb_adr_o, 32'h0);
        chk("t1_after_bus_err", {31'b0, bus_err_o}, 32'd0);

        // 2: zero-wait acks, one instruction every two cycles
        step();
        for (int i = 0; i < 3; i++) begin
            cpu_ce_i = 1'b1; cpu_addr_i = 32'h100 + 32'(4 * i);
            @(negedge clk);
            chk("t2_idle_stallreq", {31'b0, stallreq_o}, 32'd1);
            chk("t2_idle_cyc", {31'b0, wb_cyc_o}, 32'd0);
            push_exp(1'b0, 32'h1000_0000 + 32'(i));
            step();
            wb_ack_i = 1'b1; wb_dat_i = 32'h1000_0000 + 32'(i);
            @(negedge clk);
            chk("t2_busy_adr", wb_adr_o, 32'h100 + 32'(4 * i));
            chk("t2_busy_cyc", {31'b0, wb_cyc_o}, 32'd1);
            chk("t2_bus_err", {31'b0, bus_err_o}, 32'd0);
            step();
            wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        end
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("t2_end_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("t2_end_bus_err", {31'b0, bus_err_o}, 32'd0);

        // 3: stall asserted at ack, held for 4 cycles
        step();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'hc;
        step();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("t3_busy_cyc", {31'b0, wb_cyc_o}, 32'd1);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; stall = 6'b000011;
        push_exp(1'b0, 32'hDEAD_BEEF);
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_wait_data", cpu_data_o, 32'hDEAD_BEEF);
            chk("t3_wait_stallreq", {31'b0, stallreq_o}, 32'd0);
            chk("t3_wait_cyc", {31'b0, wb_cyc_o}, 32'd0);
            step();
        end
        stall = 6'b0;
        @(negedge clk);
        chk("t3_release_data", cpu_data_o, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        chk("t3_idle_data", cpu_data_o, 32'h0);
        chk("t3_idle_stallreq", {31'b0, stallreq_o}, 32'd0);

        // 4: flush in 2nd BUSY cycle with a simultaneous ack
        step();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h10;
        step();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("t4_busy1_stallreq", {31'b0, stallreq_o}, 32'd1);
        step();
        flush = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        @(negedge clk);
        chk("t4_flush_data", cpu_data_o, 32'h0);
        chk("t4_flush_stallreq", {31'b0, stallreq_o}, 32'd0);
        step();
        flush = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        @(negedge clk);
        chk("t4_after_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("t4_after_adr", wb_adr_o, 32'h0);
        chk("t4_after_data", cpu_data_o, 32'h0);
        chk("t4_after_stallreq", {31'b0, stallreq_o}, 32'd0);

        // 5: timeout after exactly 4 BUSY cycles
        step();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h20;
        step();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_busy_cyc", {31'b0, wb_cyc_o}, 32'd1);
            chk("t5_busy_bus_err", {31'b0, bus_err_o}, 32'd0);
            chk("t5_busy_stallreq", {31'b0, stallreq_o}, (i < 3) ? 32'd1 : 32'd0);
            chk("t5_busy_data", cpu_data_o, 32'h0);
            if (i == 3) push_exp(1'b1, 32'h0);
            step();
        end
        @(negedge clk);
        chk("t5_err_pulse", {31'b0, bus_err_o}, 32'd1);
        chk("t5_err_cyc", {31'b0, wb_cyc_o}, 32'd0);
        step();
        @(negedge clk);
        chk("t5_err_cleared", {31'b0, bus_err_o}, 32'd0);

        // 6: reset mid-transaction, late ack ignored
        step();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h24;
        step();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("t6_busy_cyc", {31'b0, wb_cyc_o}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_stallreq", {31'b0, stallreq_o}, 32'd0);
        chk("t6_rst_data", cpu_data_o, 32'h0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("t6_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("t6_rst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("t6_rst_adr", wb_adr_o, 32'h0);
        chk("t6_rst_late_ack_data", cpu_data_o, 32'h0);
        step();
        rst = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        @(negedge clk);
        chk("t6_idle_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("t6_idle_stallreq", {31'b0, stallreq_o}, 32'd0);
        step();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h28;
        @(negedge clk);
        chk("t6_refetch_stallreq", {31'b0, stallreq_o}, 32'd1);
        push_exp(1'b0, 32'h0000_0055);
        step();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0055;
        @(negedge clk);
        chk("t6_refetch_adr", wb_adr_o, 32'h28);
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;

        step();
        step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
